// File: rtl/pipe_hazard_ctrl.sv
// Purpose: pipeline hazard/halt controller: load-use stalls, branch flushes, HLT drain, perf counters.
// Latency: enables/flush/bubble are combinational from state+inputs; halted and counters update on the next edge.
// Backpressure: stalls PC and IF/ID for LU_STALL cycles per load-use; reset forces a safe flush/bubble.
module pipe_hazard_ctrl #(
    parameter int LU_STALL = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_rs,
    input  logic [3:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_memread,
    input  logic             ex_writereg,
    input  logic [3:0]       ex_rd,
    input  logic             br_taken,
    input  logic             id_hlt,
    input  logic             wb_hlt,
    output logic             pc_wen,
    output logic             ifid_wen,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } state_t;

    localparam logic [2:0] LU_LOAD = 3'(LU_STALL - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] dcnt;
    logic [2:0] dcnt_nxt;
    logic       lu;
    logic       stall_inc;
    logic       flush_inc;

    // Register 0 is hardwired, so a load targeting it can never create a dependency.
    assign lu = ex_memread & ex_writereg & (ex_rd != 4'd0) &
                ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));

    always_comb begin
        state_nxt   = state;
        dcnt_nxt    = dcnt;
        pc_wen      = 1'b1;
        ifid_wen    = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        case (state)
            RUN: begin
                if (br_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    flush_inc   = 1'b1;
                end else if (lu) begin
                    pc_wen      = 1'b0;
                    ifid_wen    = 1'b0;
                    idex_bubble = 1'b1;
                    stall_inc   = 1'b1;
                    if (LU_STALL > 1) begin
                        dcnt_nxt  = LU_LOAD;
                        state_nxt = LDSTALL;
                    end
                end else if (id_hlt) begin
                    // HLT itself moves on to EX; only the younger fetch is squashed.
                    pc_wen     = 1'b0;
                    ifid_flush = 1'b1;
                    state_nxt  = DRAIN;
                end
            end
            LDSTALL: begin
                pc_wen      = 1'b0;
                ifid_wen    = 1'b0;
                idex_bubble = 1'b1;
                stall_inc   = 1'b1;
                dcnt_nxt    = dcnt - 3'd1;
                if (dcnt == 3'd1) begin
                    state_nxt = RUN;
                end
            end
            DRAIN: begin
                pc_wen      = 1'b0;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                if (wb_hlt) begin
                    state_nxt = HALTED;
                end
            end
            HALTED: begin
                pc_wen      = 1'b0;
                ifid_wen    = 1'b0;
                idex_bubble = 1'b1;
            end
            default: begin
                state_nxt = RUN;
                dcnt_nxt  = 3'd0;
            end
        endcase

        if (!rst) begin
            pc_wen      = 1'b0;
            ifid_wen    = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= RUN;
            dcnt   <= 3'd0;
            halted <= 1'b0;
        end else begin
            state  <= state_nxt;
            dcnt   <= dcnt_nxt;
            halted <= (state_nxt == HALTED);
        end
    end

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three instances (LU_STALL=1, LU_STALL=3, CNT_W=2) share stimulus;
// expectations are queued when inputs are driven and compared on the following falling edge.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b1;
    logic       rst = 1'b0;
    logic [3:0] id_rs, id_rt, ex_rd;
    logic       id_use_rs, id_use_rt, ex_memread, ex_writereg;
    logic       br_taken, id_hlt, wb_hlt;

    logic        pw0, iw0, fl0, bb0, h0;
    logic        pw1, iw1, fl1, bb1, h1;
    logic        pw2, iw2, fl2, bb2, h2;
    logic [15:0] sc0, fc0, sc1, fc1;
    logic [1:0]  sc2, fc2;

    localparam logic [3:0] C_RUN = 4'b1100;  // {pc_wen, ifid_wen, ifid_flush, idex_bubble}
    localparam logic [3:0] C_STL = 4'b0001;
    localparam logic [3:0] C_BR  = 4'b1111;
    localparam logic [3:0] C_HID = 4'b0110;
    localparam logic [3:0] C_DRN = 4'b0111;
    localparam logic [3:0] C_HLT = 4'b0001;
    localparam logic [3:0] C_RST = 4'b0011;

    typedef struct {
        int         dut;
        string      tag;
        logic [3:0] ctl;
        int         hlt;
        int         stl;
        int         fls;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LU_STALL(1), .CNT_W(16)) u_ls1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_memread(ex_memread), .ex_writereg(ex_writereg), .ex_rd(ex_rd), .br_taken(br_taken),
        .id_hlt(id_hlt), .wb_hlt(wb_hlt), .pc_wen(pw0), .ifid_wen(iw0), .ifid_flush(fl0),
        .idex_bubble(bb0), .halted(h0), .stall_cnt(sc0), .flush_cnt(fc0));

    pipe_hazard_ctrl #(.LU_STALL(3), .CNT_W(16)) u_ls3 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_memread(ex_memread), .ex_writereg(ex_writereg), .ex_rd(ex_rd), .br_taken(br_taken),
        .id_hlt(id_hlt), .wb_hlt(wb_hlt), .pc_wen(pw1), .ifid_wen(iw1), .ifid_flush(fl1),
        .idex_bubble(bb1), .halted(h1), .stall_cnt(sc1), .flush_cnt(fc1));

    pipe_hazard_ctrl #(.LU_STALL(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_memread(ex_memread), .ex_writereg(ex_writereg), .ex_rd(ex_rd), .br_taken(br_taken),
        .id_hlt(id_hlt), .wb_hlt(wb_hlt), .pc_wen(pw2), .ifid_wen(iw2), .ifid_flush(fl2),
        .idex_bubble(bb2), .halted(h2), .stall_cnt(sc2), .flush_cnt(fc2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
        end
    endtask

    task automatic expct(input int dut, input string tag, input logic [3:0] ctl,
                         input int hlt, input int stl, input int fls);
        exp_t e;
        e.dut = dut; e.tag = tag; e.ctl = ctl; e.hlt = hlt; e.stl = stl; e.fls = fls;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t        e;
            logic [3:0]  c;
            logic [31:0] h, s, f;
            e = exp_q.pop_front();
            case (e.dut)
                0:       begin c = {pw0, iw0, fl0, bb0}; h = 32'(h0); s = 32'(sc0); f = 32'(fc0); end
                1:       begin c = {pw1, iw1, fl1, bb1}; h = 32'(h1); s = 32'(sc1); f = 32'(fc1); end
                default: begin c = {pw2, iw2, fl2, bb2}; h = 32'(h2); s = 32'(sc2); f = 32'(fc2); end
            endcase
            chk({e.tag, ".ctl"}, 32'(c), 32'(e.ctl));
            chk({e.tag, ".halted"}, h, 32'(e.hlt));
            chk({e.tag, ".stall_cnt"}, s, 32'(e.stl));
            chk({e.tag, ".flush_cnt"}, f, 32'(e.fls));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 4'd0; id_rt = 4'd0; ex_rd = 4'd0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; ex_memread = 1'b0; ex_writereg = 1'b0;
        br_taken = 1'b0; id_hlt = 1'b0; wb_hlt = 1'b0;
    endtask

    task automatic set_lu();
        idle();
        ex_memread = 1'b1; ex_writereg = 1'b1; ex_rd = 4'd3; id_use_rt = 1'b1; id_rt = 4'd3;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) expct(d, "reset", C_RST, 0, 0, 0);
        step();

        // load-use with 1 and 3 stall cycles side by side
        rst = 1'b1;
        idle(); expct(0, "run", C_RUN, 0, 0, 0); expct(1, "run3", C_RUN, 0, 0, 0); step();
        set_lu(); expct(0, "lu1", C_STL, 0, 0, 0); expct(1, "lu3_c1", C_STL, 0, 0, 0); step();
        idle(); expct(0, "lu1_done", C_RUN, 0, 1, 0); expct(1, "lu3_c2", C_STL, 0, 1, 0); step();
        idle(); expct(1, "lu3_c3", C_STL, 0, 2, 0); step();
        idle(); expct(1, "lu3_done", C_RUN, 0, 3, 0); expct(0, "lu1_hold", C_RUN, 0, 1, 0); step();

        // register 0 never stalls
        idle(); ex_memread = 1'b1; ex_writereg = 1'b1; ex_rd = 4'd0; id_rs = 4'd0; id_use_rs = 1'b1;
        expct(0, "r0", C_RUN, 0, 1, 0); expct(1, "r0_3", C_RUN, 0, 3, 0); step();

        // wb_hlt outside DRAIN is ignored
        idle(); wb_hlt = 1'b1; expct(0, "wb_run", C_RUN, 0, 1, 0); step();
        idle(); expct(0, "wb_run_after", C_RUN, 0, 1, 0); step();

        // branch beats load-use
        do_reset();
        set_lu(); br_taken = 1'b1; expct(0, "br_lu", C_BR, 0, 0, 0); expct(1, "br_lu3", C_BR, 0, 0, 0); step();
        idle(); expct(0, "br_after", C_RUN, 0, 0, 1); expct(1, "br_after3", C_RUN, 0, 0, 1); step();

        // halt sequence
        idle(); id_hlt = 1'b1; expct(0, "hlt_id", C_HID, 0, 0, 1); step();
        idle(); br_taken = 1'b1; expct(0, "drain_br", C_DRN, 0, 0, 1); step();
        set_lu(); expct(0, "drain_lu", C_DRN, 0, 0, 1); step();
        idle(); wb_hlt = 1'b1; expct(0, "drain_wb", C_DRN, 0, 0, 1); step();
        idle(); br_taken = 1'b1; id_hlt = 1'b1; expct(0, "halted", C_HLT, 1, 0, 1); step();
        idle(); expct(0, "halted_hold", C_HLT, 1, 0, 1); step();

        // saturation with 2-bit counters, then reset in DRAIN
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_lu(); expct(2, $sformatf("sat%0d", k), C_STL, 0, (k > 3) ? 3 : k, 0); step();
        end
        idle(); expct(2, "sat_end", C_RUN, 0, 3, 0); step();
        idle(); id_hlt = 1'b1; expct(2, "sat_hlt", C_HID, 0, 3, 0); step();
        idle(); expct(2, "sat_drain", C_DRN, 0, 3, 0); step();
        rst = 1'b0; expct(2, "rst_drain", C_RST, 0, 0, 0); expct(0, "rst_halted", C_RST, 0, 0, 0); step();
        rst = 1'b1; idle(); expct(2, "release", C_RUN, 0, 0, 0); step();
        idle(); expct(2, "release2", C_RUN, 0, 0, 0); step();

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter LU_STALL, default 1, meaning stall cycles inserted per load-use hazard; legal range 1..7.
REQ-002 Parameter CNT_W, default 16, meaning width of each performance counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 id_rs, id_rt  input  4 each  source register ids of the instruction in ID.
REQ-006 id_use_rs, id_use_rt  input  1 each  ID instruction actually reads rs / rt.
REQ-007 ex_memread, ex_writereg  input  1 each  MemRead / WriteReg of the instruction in EX (ID/EX register outputs).
REQ-008 ex_rd  input  4  destination register id of the instruction in EX.
REQ-009 br_taken  input  1  taken branch resolved in EX this cycle.
REQ-010 id_hlt, wb_hlt  input  1 each  HLT decoded in ID / HLT reached WB.
REQ-011 pc_wen, ifid_wen  output  1 each  PC and IF/ID register write enables.
REQ-012 ifid_flush  output  1  load NOP into IF/ID next edge.
REQ-013 idex_bubble  output  1  zero all ID/EX control bits next edge.
REQ-014 halted  output  1  registered; processor halted.
REQ-015 stall_cnt, flush_cnt  output  CNT_W each  registered performance counters.

Function
REQ-016 The block SHALL implement FSM states RUN, LDSTALL, DRAIN, HALTED.
REQ-017 The block SHALL compute hazard lu = ex_memread & ex_writereg & (ex_rd != 0) & ((id_use_rs & id_rs == ex_rd) | (id_use_rt & id_rt == ex_rd)); register 0 never causes a hazard.
REQ-018 RUN, no event: pc_wen=1, ifid_wen=1, ifid_flush=0, idex_bubble=0.
REQ-019 RUN priority, highest first: br_taken, lu, id_hlt.
REQ-020 RUN & br_taken: ifid_flush=1, idex_bubble=1, pc_wen=1, ifid_wen=1; flush_cnt increments; state stays RUN; a simultaneous lu or id_hlt is discarded.
REQ-021 RUN & lu & !br_taken: pc_wen=0, ifid_wen=0, idex_bubble=1, ifid_flush=0; stall_cnt increments; if LU_STALL=1 stay RUN, else load down-counter with LU_STALL-1 and go LDSTALL.
REQ-022 LDSTALL: pc_wen=0, ifid_wen=0, idex_bubble=1, ifid_flush=0 every cycle; stall_cnt increments; down-counter decrements; on the cycle it equals 1, next state RUN; total stalled cycles per hazard = LU_STALL exactly; br_taken, lu, id_hlt ignored.
REQ-023 RUN & id_hlt & !lu & !br_taken: HLT proceeds into ID/EX normally (idex_bubble=0); pc_wen=0, ifid_wen=1, ifid_flush=1; next state DRAIN.
REQ-024 DRAIN: pc_wen=0, ifid_wen=1, ifid_flush=1, idex_bubble=1 every cycle; br_taken, lu, id_hlt ignored; on wb_hlt next state HALTED.
REQ-025 HALTED: pc_wen=0, ifid_wen=0, ifid_flush=0, idex_bubble=1, halted=1; exit only via reset.
REQ-026 wb_hlt in RUN or LDSTALL SHALL be ignored.
REQ-027 Counters SHALL saturate at all-ones and never wrap.
REQ-028 stall_cnt SHALL count only load-use stall cycles, never DRAIN or HALTED cycles.
REQ-029 pc_wen, ifid_wen, ifid_flush and idex_bubble SHALL be combinational from state and inputs, with zero-cycle latency; halted and counters SHALL be registered.

Reset
REQ-030 While rst=0: state=RUN, down-counter=0, halted=0, stall_cnt=0, flush_cnt=0.
REQ-031 While rst=0, outputs SHALL be forced to pc_wen=0, ifid_wen=0, ifid_flush=1, idex_bubble=1, regardless of clk.
REQ-032 Reset assertion mid-LDSTALL or mid-DRAIN SHALL abort immediately; the first edge after release evaluates from RUN.

Verification
REQ-033 Load-use, LU_STALL=1: ex_memread=1, ex_writereg=1, ex_rd=3, id_use_rt=1, id_rt=3 -> exactly one cycle with pc_wen=0, idex_bubble=1; stall_cnt=1.
REQ-034 LU_STALL=3, same stimulus -> pc_wen=0 for exactly 3 consecutive cycles, then 1; stall_cnt=3.
REQ-035 Register 0: ex_rd=0, id_rs=0, id_use_rs=1, ex_memread=1 -> no stall; pc_wen=1.
REQ-036 br_taken=1 together with the lu condition -> ifid_flush=1, idex_bubble=1, pc_wen=1; flush_cnt=1, stall_cnt=0.
REQ-037 id_hlt=1, then wb_hlt=1 three cycles later -> pc_wen=0 from the id_hlt cycle on; halted=1 one edge after wb_hlt; br_taken=1 in DRAIN changes nothing.
REQ-038 Counter saturation (CNT_W=2): 5 stall cycles -> stall_cnt=3; assert rst=0 mid-DRAIN -> halted=0 and counters=0 immediately, then RUN outputs after release.
